// File: rtl/dcache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_refill_ctrl
//
// Services one data-cache miss at a time. If the victim line is dirty it is
// first written back to memory as an 8-beat burst read out of the data RAM.
// The new line is then fetched as an 8-beat read burst and written into the
// data RAM. The controller uses data RAM port B only while it moves beats.
// Outside those cycles ram_en is low, so port A owns the RAM.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req, req_wb       miss request (sampled in IDLE only), victim-dirty flag
//   req_idx           line index; req_tag / wb_tag are PA[31:5] of fill/victim
//   busy, done, err   not-idle, one-cycle completion, one-cycle burst-length error
//   ram_*             data RAM port B (ram_dout is combinational read data)
//   rd_req/addr/ack   read address handshake
//   rd_valid/data/last read beats (no backpressure)
//   wr_req/addr/ack   write address handshake
//   wr_valid/data/last/ready  write beats
//   wr_done           write response
// ---------------------------------------------------------------------------
module dcache_refill_ctrl #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             req_wb,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [26:0]      req_tag,
  input  logic [26:0]      wb_tag,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ram_en,
  output logic [3:0]       ram_we,
  output logic [IDX_W+2:0] ram_addr,
  output logic [31:0]      ram_din,
  input  logic [31:0]      ram_dout,
  output logic             rd_req,
  output logic [31:0]      rd_addr,
  input  logic             rd_ack,
  input  logic             rd_valid,
  input  logic [31:0]      rd_data,
  input  logic             rd_last,
  output logic             wr_req,
  output logic [31:0]      wr_addr,
  input  logic             wr_ack,
  output logic             wr_valid,
  output logic [31:0]      wr_data,
  output logic             wr_last,
  input  logic             wr_ready,
  input  logic             wr_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_ADDR = 3'd1,
    S_WB_DATA = 3'd2,
    S_WB_RESP = 3'd3,
    S_RF_ADDR = 3'd4,
    S_RF_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t           state, state_d;
  logic [2:0]       cnt, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [26:0]      tag_q, tag_d;
  logic [26:0]      wbtag_q, wbtag_d;

  // The eighth beat of a burst. Burst progress follows this counter only.
  // rd_last is used only to report a length mismatch.
  logic last_beat;
  assign last_beat = (cnt == 3'd7);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      idx_q   <= '0;
      tag_q   <= '0;
      wbtag_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      wbtag_q <= wbtag_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath-update logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block. No path can
  // leave a variable unassigned, so no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx_q;
    tag_d   = tag_q;
    wbtag_d = wbtag_q;

    unique case (state)
      S_IDLE: begin
        if (req) begin
          idx_d   = req_idx;
          tag_d   = req_tag;
          wbtag_d = wb_tag;
          state_d = req_wb ? S_WB_ADDR : S_RF_ADDR;
        end
      end

      S_WB_ADDR: begin
        if (wr_ack) begin
          cnt_d   = 3'd0;
          state_d = S_WB_DATA;
        end
      end

      S_WB_DATA: begin
        // A ready on the final beat finishes the burst in this same cycle.
        // wr_done is not looked at here.
        if (wr_ready) begin
          cnt_d = cnt + 3'd1;
          if (last_beat) state_d = S_WB_RESP;
        end
      end

      S_WB_RESP: begin
        if (wr_done) state_d = S_RF_ADDR;
      end

      S_RF_ADDR: begin
        if (rd_ack) begin
          cnt_d   = 3'd0;
          state_d = S_RF_DATA;
        end
      end

      S_RF_DATA: begin
        if (rd_valid) begin
          cnt_d = cnt + 3'd1;
          if (last_beat) state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  // Address and data outputs are zero outside the states that drive them.
  // As a result, every output is zero in IDLE, and IDLE is the reset state.
  always_comb begin
    busy     = (state != S_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 4'h0;
    ram_addr = '0;
    ram_din  = 32'h0;
    rd_req   = 1'b0;
    rd_addr  = 32'h0;
    wr_req   = 1'b0;
    wr_addr  = 32'h0;
    wr_valid = 1'b0;
    wr_data  = 32'h0;
    wr_last  = 1'b0;

    unique case (state)
      S_WB_ADDR: begin
        wr_req  = 1'b1;
        wr_addr = {wbtag_q, 5'b0};
      end

      S_WB_DATA: begin
        // The RAM read is combinational. The victim word goes out in the
        // same cycle that its address is presented.
        ram_en   = 1'b1;
        ram_addr = {idx_q, cnt};
        wr_valid = 1'b1;
        wr_data  = ram_dout;
        wr_last  = last_beat;
      end

      S_RF_ADDR: begin
        rd_req  = 1'b1;
        rd_addr = {tag_q, 5'b0};
      end

      S_RF_DATA: begin
        if (rd_valid) begin
          ram_en   = 1'b1;
          ram_we   = 4'hF;
          ram_addr = {idx_q, cnt};
          ram_din  = rd_data;
          err      = (rd_last != last_beat);
        end
      end

      S_DONE: done = 1'b1;

      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_refill_ctrl
//
// Directed bench for dcache_refill_ctrl (IDX_W = 4). A behavioural data RAM
// answers port B. The bench drives inputs 1 ns after each rising edge and
// compares outputs 1 ns later. A falling-edge monitor counts RAM writes,
// done/err pulses and accepted write beats.
// ---------------------------------------------------------------------------
module tb_dcache_refill_ctrl;

  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req, req_wb;
  logic [IDX_W-1:0] req_idx;
  logic [26:0]      req_tag, wb_tag;
  logic             busy, done, err;
  logic             ram_en;
  logic [3:0]       ram_we;
  logic [IDX_W+2:0] ram_addr;
  logic [31:0]      ram_din, ram_dout;
  logic             rd_req, rd_ack, rd_valid, rd_last;
  logic [31:0]      rd_addr, rd_data;
  logic             wr_req, wr_ack, wr_valid, wr_last, wr_ready, wr_done;
  logic [31:0]      wr_addr, wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor statistics.
  int          wcnt     = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic [31:0] wq[$];

  logic [31:0] mem [0:(1<<(IDX_W+3))-1];

  always #5 clk = ~clk;

  dcache_refill_ctrl #(.IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_wb   (req_wb),
    .req_idx  (req_idx),
    .req_tag  (req_tag),
    .wb_tag   (wb_tag),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_ack   (wr_ack),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .wr_ready (wr_ready),
    .wr_done  (wr_done)
  );

  // Behavioural data RAM: combinational read, byte-enabled synchronous write.
  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_en === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b] === 1'b1) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (ram_en === 1'b1 && ram_we !== 4'h0) wcnt++;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (wr_valid === 1'b1 && wr_ready === 1'b1) wq.push_back(wr_data);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_flags"}, 64'({busy, done, err, ram_en, rd_req, wr_req, wr_valid, wr_last}), 64'h0);
    check({tag, "_ram_we"},   64'(ram_we),   64'h0);
    check({tag, "_ram_addr"}, 64'(ram_addr), 64'h0);
    check({tag, "_ram_din"},  64'(ram_din),  64'h0);
    check({tag, "_rd_addr"},  64'(rd_addr),  64'h0);
    check({tag, "_wr_addr"},  64'(wr_addr),  64'h0);
    check({tag, "_wr_data"},  64'(wr_data),  64'h0);
  endtask

  // Presents a request for one cycle. On return the controller is in WB_ADDR
  // or RF_ADDR.
  task automatic start_req(input logic wb, input int idx, input logic [26:0] tag,
                           input logic [26:0] wtag);
    req = 1'b1; req_wb = wb; req_idx = IDX_W'(idx); req_tag = tag; wb_tag = wtag;
    tick();
    req = 1'b0; req_wb = 1'b0;
  endtask

  task automatic rf_addr_phase(input string tag, input logic [31:0] exp_addr);
    #1;
    check({tag, "_rd_req"},  64'(rd_req),  64'h1);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'(exp_addr));
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  // Delivers 8 read beats with 'gap' empty cycles between them. rd_last is
  // also raised on bad_beat, which must flag err in that cycle only.
  task automatic rf_beats(input string tag, input logic [31:0] base, input int a0,
                          input int gap, input int bad_beat);
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1;
      rd_data  = base + 32'(i);
      rd_last  = (i == 7) || (i == bad_beat);
      #1;
      check({tag, "_ram_en"},   64'(ram_en),   64'h1);
      check({tag, "_ram_we"},   64'(ram_we),   64'hF);
      check({tag, "_ram_addr"}, 64'(ram_addr), 64'(a0 + i));
      check({tag, "_ram_din"},  64'(ram_din),  64'(base + 32'(i)));
      check({tag, "_err"},      64'(err),      64'(i == bad_beat));
      tick();
      rd_valid = 1'b0;
      rd_last  = 1'b0;
      if (i != 7) begin
        for (int g = 0; g < gap; g++) begin
          #1;
          check({tag, "_gap_ram_en"}, 64'(ram_en), 64'h0);
          tick();
        end
      end
    end
  endtask

  task automatic done_phase(input string tag);
    #1;
    check({tag, "_done"}, 64'(done), 64'h1);
    check({tag, "_busy_done"}, 64'(busy), 64'h1);
    tick();
    check({tag, "_done_clr"}, 64'(done), 64'h0);
    check({tag, "_idle"}, 64'(busy), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; req_wb = 1'b0; req_idx = '0; req_tag = '0; wb_tag = '0;
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0; rd_last = 1'b0;
    wr_ack = 1'b0; wr_ready = 1'b0; wr_done = 1'b0;
    for (int i = 0; i < (1 << (IDX_W + 3)); i++) mem[i] = 32'h0;

    // ---- reset state ----
    tick(); tick();
    rst = 1'b0;
    #1 check_idle_outputs("reset");

    // ---- stray handshakes in IDLE are ignored ----
    rd_ack = 1'b1; wr_ack = 1'b1; rd_valid = 1'b1; wr_ready = 1'b1; wr_done = 1'b1;
    tick();
    #1;
    check("idle_stray_busy", 64'(busy), 64'h0);
    check("idle_stray_ram_en", 64'(ram_en), 64'h0);
    rd_ack = 1'b0; wr_ack = 1'b0; rd_valid = 1'b0; wr_ready = 1'b0; wr_done = 1'b0;
    tick();

    // ---- clean miss: idx 3, tag 0x1234567, rd_ack on the second cycle ----
    start_req(1'b0, 3, 27'h1234567, 27'h0);
    #1;
    check("clean_busy", 64'(busy), 64'h1);
    check("clean_no_wr_req", 64'(wr_req), 64'h0);
    wr_ack = 1'b1;                               // must be ignored outside WB_ADDR
    tick();
    wr_ack = 1'b0;
    rf_addr_phase("clean", 32'h2468ACE0);
    req = 1'b1; req_idx = 4'd9; req_wb = 1'b1;   // a new request while busy is ignored
    rf_beats("clean", 32'hA0, 24, 0, -1);
    req = 1'b0; req_wb = 1'b0;
    done_phase("clean");
    for (int i = 0; i < 8; i++) check("clean_mem", 64'(mem[24 + i]), 64'(32'hA0 + i));
    check("clean_wcnt", 64'(wcnt), 64'd8);
    check("clean_done_cnt", 64'(done_cnt), 64'd1);

    // ---- dirty miss: idx 0, victim tag 1, RAM holds 0..7 ----
    for (int i = 0; i < 8; i++) mem[i] = 32'(i);
    start_req(1'b1, 0, 27'h0000002, 27'h0000001);
    #1;
    check("dirty_wr_req", 64'(wr_req), 64'h1);
    check("dirty_wr_addr", 64'(wr_addr), 64'h20);
    check("dirty_no_rd_req", 64'(rd_req), 64'h0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_ready = 1'b1;
      wr_done  = (i == 2);                       // early response must be ignored
      #1;
      check("dirty_wr_valid", 64'(wr_valid), 64'h1);
      check("dirty_wr_data", 64'(wr_data), 64'(i));
      check("dirty_wr_last", 64'(wr_last), 64'(i == 7));
      check("dirty_ram_rd", 64'({ram_en, ram_we}), 64'h10);
      check("dirty_ram_addr", 64'(ram_addr), 64'(i));
      tick();
    end
    wr_ready = 1'b0; wr_done = 1'b0;
    #1;
    check("dirty_resp_quiet", 64'({wr_valid, wr_req, rd_req, ram_en}), 64'h0);
    check("dirty_resp_busy", 64'(busy), 64'h1);
    tick();
    #1 check("dirty_wait_done", 64'(rd_req), 64'h0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    rf_addr_phase("dirty", 32'h40);
    rf_beats("dirty", 32'hB0, 0, 0, -1);
    done_phase("dirty");
    for (int i = 0; i < 8; i++) check("dirty_mem", 64'(mem[i]), 64'(32'hB0 + i));
    check("dirty_wcnt", 64'(wcnt), 64'd16);

    // ---- backpressure: wr_ready toggles, read beats with 2-cycle gaps ----
    for (int i = 0; i < 8; i++) mem[40 + i] = 32'hC0 + 32'(i);
    wq.delete();
    start_req(1'b1, 5, 27'h0000004, 27'h0000003);
    #1 check("bp_wr_addr", 64'(wr_addr), 64'h60);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (cyc < 40) begin
        wr_ready = (cyc % 2 == 0);
        #1;
        if (wr_valid !== 1'b1) break;
        tick();
        cyc++;
      end
      wr_ready = 1'b0;
      check("bp_wb_cycles", 64'(cyc), 64'd15);
    end
    check("bp_wb_beats", 64'(wq.size()), 64'd8);
    for (int i = 0; i < wq.size(); i++) check("bp_wb_data", 64'(wq[i]), 64'(32'hC0 + i));
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    rf_addr_phase("bp", 32'h80);
    rf_beats("bp", 32'hD0, 40, 2, -1);
    done_phase("bp");
    for (int i = 0; i < 8; i++) check("bp_mem", 64'(mem[40 + i]), 64'(32'hD0 + i));
    check("bp_wcnt", 64'(wcnt), 64'd24);
    check("bp_err_cnt", 64'(err_cnt), 64'd0);

    // ---- burst error: rd_last on beat 6 (index 5), top tag ----
    start_req(1'b0, 1, 27'h7FFFFFF, 27'h0);
    rf_addr_phase("berr", 32'hFFFFFFE0);
    rf_beats("berr", 32'h100, 8, 0, 5);
    done_phase("berr");
    check("berr_err_cnt", 64'(err_cnt), 64'd1);
    check("berr_wcnt", 64'(wcnt), 64'd32);
    check("berr_mem_last", 64'(mem[15]), 64'h107);

    // ---- reset during RF_DATA after beat 3 ----
    for (int i = 16; i < 24; i++) mem[i] = 32'h55555555;
    start_req(1'b0, 2, 27'h0000007, 27'h0);
    rf_addr_phase("abort", 32'hE0);
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1; rd_data = 32'h200 + 32'(i);
      tick();
    end
    rd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_valid = 1'b1; rd_data = 32'hEE;          // stray beat after the abort
    #1 check_idle_outputs("abort");
    tick();
    rd_valid = 1'b0;
    check("abort_wcnt", 64'(wcnt), 64'd35);
    check("abort_mem_beat3", 64'(mem[18]), 64'h202);
    check("abort_mem_untouched", 64'(mem[19]), 64'h55555555);
    check("abort_done_cnt", 64'(done_cnt), 64'd4);

    // ---- a new request is accepted after the abort ----
    start_req(1'b0, 6, 27'h0000005, 27'h0);
    #1 check("post_abort_busy", 64'(busy), 64'h1);
    rf_addr_phase("post", 32'hA0);
    rf_beats("post", 32'hE0, 48, 0, -1);
    done_phase("post");
    check("post_mem_first", 64'(mem[48]), 64'hE0);
    check("post_done_cnt", 64'(done_cnt), 64'd5);
    check("post_wcnt", 64'(wcnt), 64'd43);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_refill_ctrl.md
DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning cache line index width; RAM word address width = IDX_W+3 (8 words per line).
REQ-002 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req  in  1  miss service request, sampled in IDLE only; req_wb  in  1  victim line dirty.
REQ-005 SHALL have ports: req_idx  in  IDX_W  line index; req_tag  in  27  fill PA[31:5]; wb_tag  in  27  victim PA[31:5].
REQ-006 SHALL have ports: busy  out  1  controller not in IDLE; done  out  1  one-cycle completion pulse; err  out  1  one-cycle burst-length error pulse.
REQ-007 SHALL have ports: ram_en  out  1  port-B select of data RAM; ram_we  out  4  byte write enables; ram_addr  out  IDX_W+3  word address; ram_din  out  32  write data; ram_dout  in  32  combinational read data.
REQ-008 SHALL have ports: rd_req  out  1, rd_addr  out  32, rd_ack  in  1 (read address handshake); rd_valid  in  1, rd_data  in  32, rd_last  in  1 (read beats, no backpressure).
REQ-009 SHALL have ports: wr_req  out  1, wr_addr  out  32, wr_ack  in  1 (write address handshake); wr_valid  out  1, wr_data  out  32, wr_last  out  1, wr_ready  in  1 (write beats); wr_done  in  1 (write response).

Function
REQ-010 SHALL implement states IDLE, WB_ADDR, WB_DATA, WB_RESP, RF_ADDR, RF_DATA, DONE, with a 3-bit beat counter cnt.
REQ-011 IDLE: on req=1 SHALL latch req_idx/req_tag/wb_tag and go to WB_ADDR if req_wb=1, else RF_ADDR; req during non-IDLE states SHALL be ignored.
REQ-012 WB_ADDR: wr_req=1, wr_addr={wb_tag,5'b0}; on wr_ack SHALL clear cnt and go WB_DATA.
REQ-013 WB_DATA: ram_en=1, ram_we=0, ram_addr={idx,cnt}, wr_valid=1, wr_data=ram_dout (same cycle), wr_last=(cnt==7); on wr_ready cnt SHALL increment; on wr_ready with cnt==7 SHALL go WB_RESP.
REQ-014 WB_RESP: all request/valid outputs 0; on wr_done SHALL go RF_ADDR.
REQ-015 RF_ADDR: rd_req=1, rd_addr={tag,5'b0}; on rd_ack SHALL clear cnt and go RF_DATA.
REQ-016 RF_DATA: in each cycle with rd_valid=1: ram_en=1, ram_we=4'hF, ram_addr={idx,cnt}, ram_din=rd_data, cnt increments; with rd_valid=0: ram_en=0, ram_we=0.
REQ-017 RF_DATA: on rd_valid with cnt==7 SHALL go DONE; err SHALL pulse in any beat where rd_last != (cnt==7); transition SHALL depend on cnt only.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-019 ram_en SHALL be 0 whenever ram_we and ram_addr are not driven by REQ-013/REQ-016, so port A owns the RAM otherwise.
REQ-020 Counter SHALL wrap 7->0 without overflow side effects; rd_ack/wr_ack SHALL be honoured only in their address states.
REQ-021 Simultaneous wr_ready and final beat SHALL complete in that cycle; wr_done arriving in WB_DATA SHALL be ignored.

Reset
REQ-022 On rst=1 at a clock edge SHALL enter IDLE, cnt=0, latched fields 0; all outputs 0 (busy, done, err, ram_en, ram_we, rd_req, wr_req, wr_valid, wr_last, addresses, data).
REQ-023 Reset mid-operation SHALL abort immediately; no RAM write SHALL occur in the cycle after rst is sampled.

Verification
REQ-024 Clean miss: req=1, req_wb=0, idx=3, tag=0x1234567, rd_ack cycle 2, 8 back-to-back beats 0xA0..0xA7 -> rd_addr=0x2468ACE0, RAM words 24..31 = 0xA0..0xA7, ram_we=4'hF, done pulse one cycle after last beat.
REQ-025 Dirty miss: req_wb=1, wb_tag=0x0000001, idx=0, RAM holds 0..7 -> wr_addr=0x20, wr_data 0..7 with wr_last on beat 8, refill starts only after wr_done.
REQ-026 Backpressure/gaps: wr_ready toggling 1,0,1,... and rd_valid gaps of 2 cycles -> each word transferred exactly once, ram_en=0 in gap cycles.
REQ-027 Burst error: rd_last asserted on beat 6 -> err pulse that cycle, refill continues to 8 beats, done still pulses.
REQ-028 Reset in RF_DATA after beat 3 -> next cycle all outputs 0, IDLE, no further RAM writes; new req accepted afterwards.
